// File: rtl/alu_exec_stage.sv
// ALU execute stage: ctrl decode, combinational ALU, valid/ready result FIFO.
// Optional macro ALU_EXEC_OVF_EN adds a per-entry signed overflow flag (out_ovf).
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam int M = WIDTH - 1;

  logic             w_add, w_sub, w_and, w_or, w_slt, w_ill;
  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic             w_lt, w_zero, w_push, w_pop;

  logic [WIDTH-1:0] r_res [DEPTH];
  logic [DEPTH-1:0] r_zero, r_ill;
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last_res;
  logic             r_last_zero, r_last_ill;

  assign w_add = (in_ctrl == 4'b0010);
  assign w_sub = (in_ctrl == 4'b0110);
  assign w_and = (in_ctrl == 4'b0000);
  assign w_or  = (in_ctrl == 4'b0001);
  assign w_slt = (in_ctrl == 4'b0111);
  assign w_ill = !(w_add | w_sub | w_and | w_or | w_slt);

  assign w_sum  = in_a + in_b;
  assign w_diff = in_a - in_b;
  assign w_lt   = $signed(in_a) < $signed(in_b);

  // ALU result select; unsupported codes yield zero
  always_comb begin
    w_res = '0;
    unique case (1'b1)
      w_add:   w_res = w_sum;
      w_sub:   w_res = w_diff;
      w_and:   w_res = in_a & in_b;
      w_or:    w_res = in_a | in_b;
      w_slt:   w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_res = '0;
    endcase
  end

  assign w_zero = (w_res == '0);

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_res[i] <= '0;
      r_zero <= '0;
      r_ill  <= '0;
    end else if (w_push) begin
      r_res[r_wr]  <= w_res;
      r_zero[r_wr] <= w_zero;
      r_ill[r_wr]  <= w_ill;
    end
  end

  // Hold the last popped entry so outputs stay put when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_res  <= '0;
      r_last_zero <= 1'b0;
      r_last_ill  <= 1'b0;
    end else if (w_pop) begin
      r_last_res  <= r_res[r_rd];
      r_last_zero <= r_zero[r_rd];
      r_last_ill  <= r_ill[r_rd];
    end
  end

  assign out_result  = out_valid ? r_res[r_rd]  : r_last_res;
  assign out_zero    = out_valid ? r_zero[r_rd] : r_last_zero;
  assign out_illegal = out_valid ? r_ill[r_rd]  : r_last_ill;

`ifdef ALU_EXEC_OVF_EN
  logic             w_ovf;
  logic [DEPTH-1:0] r_ovf;
  logic             r_last_ovf;

  assign w_ovf =
    (w_add & (in_a[M] == in_b[M]) & (w_sum[M] != in_a[M])) |
    (w_sub & (in_a[M] != in_b[M]) & (w_diff[M] != in_a[M]));

  // Overflow flag storage, same lifetime as the result entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= '0;
      r_last_ovf <= 1'b0;
    end else begin
      if (w_push) r_ovf[r_wr] <= w_ovf;
      if (w_pop)  r_last_ovf  <= r_ovf[r_rd];
    end
  end

  assign out_ovf = out_valid ? r_ovf[r_rd] : r_last_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed ops, back-pressure, reset.
// Expected entries are queued at acceptance and checked by a monitor.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_ctrl = 4'h0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_illegal;
`ifdef ALU_EXEC_OVF_EN
  logic         out_ovf;
`endif

  alu_exec_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal)
`ifdef ALU_EXEC_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         il;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare head against scoreboard whenever a pop will occur
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %h want none", out_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", out_result, e.r);
        chk("zero", 32'(out_zero), 32'(e.z));
        chk("illegal", 32'(out_illegal), 32'(e.il));
`ifdef ALU_EXEC_OVF_EN
        chk("ovf", 32'(out_ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] r,
                      input logic z, input logic il, input logic ov);
    int n;
    exp_t e;
    n = 0;
    in_ctrl  = c;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
      in_valid = 1'b0;
      return;
    end
    e.r  = r;
    e.z  = z;
    e.il = il;
    e.ov = ov;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: left %0d want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single add, one-cycle latency
    out_ready = 1'b1;
    send(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", out_result, 32'd12);
    @(posedge clk);
    #1;
    chk("lat_empty", 32'(out_valid), 32'd0);

    // Sub to zero, slt both ways
    send(4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-pressure: two fit, third waits
    out_ready = 1'b0;
    send(4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0);
    in_ctrl  = 4'b0010;
    in_a     = 32'd1;
    in_b     = 32'd1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_result, 32'h30);
    repeat (2) @(negedge clk);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    chk("bp_stall_head", out_result, 32'h30);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    drain();

    // Full with pop: no push; then push and pop together
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);
    send(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_ctrl   = 4'b0110;
    in_a      = 32'd9;
    in_b      = 32'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    chk("full_pop_valid", 32'(out_valid), 32'd1);
    chk("full_pop_head", out_result, 32'd3);
    send(4'b0110, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_ready", 32'(in_ready), 32'd1);
    chk("pp_head", out_result, 32'd5);
    drain();

    // Unsupported ctrl code
    send(4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1'b0);
    send(4'b0011, 32'd8, 32'd8, 32'd0, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset with two entries buffered
    out_ready = 1'b0;
    send(4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", out_result, 32'd0);
    chk("mrst_zero", 32'(out_zero), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_empty", 32'(out_valid), 32'd0);

    // Wrap-around arithmetic and overflow flag
    out_ready = 1'b1;
    send(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send(4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    drain();

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
